// File: rtl/mips_fetch_defs.sv
// ---------------------------------------------------------------------------
// mips_fetch_defs
// Shared definitions for the fetch stage: FSM state encoding, instruction
// word width and the sequential PC increment.
// ---------------------------------------------------------------------------
package mips_fetch_defs;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_INC  = 4;

    // REQ : a read request may be presented to instruction memory
    // WAIT: one read is outstanding, its response will be queued
    // DROP: one read is outstanding, its response is stale and discarded
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               empties the queue on the next edge (wins over push/pop)
//   push, push_data     write one entry (ignored when full)
//   pop                 retire the head entry (ignored when empty)
//   head_data           current head entry (storage output, no bypass)
//   count, full, empty  occupancy status
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Entry storage; cleared on reset so the head reads as zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit_prefetch.sv
// ---------------------------------------------------------------------------
// fetch_unit_prefetch
// Fetch stage with a prefetch queue. Holds the fetch PC, issues one word read
// at a time to instruction memory, queues {pc, instr} pairs for decode and
// handles redirects (jr > jump > taken branch) by flushing the queue and
// discarding any response that is still in flight.
// Ports:
//   imem_req_valid/ready/addr   read request (addr = fetch PC)
//   imem_rsp_valid/data         read response
//   ex_pc, branch, zero_flag,
//   br_offset, jump, jump_index,
//   jr, jr_target               redirect information from execute
//   dec_valid/ready/instr/pc    queue head towards decode
// ---------------------------------------------------------------------------
module fetch_unit_prefetch
    import mips_fetch_defs::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      FQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic               branch,
    input  logic               zero_flag,
    input  logic [XLEN-1:0]    br_offset,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    input  logic               jr,
    input  logic [XLEN-1:0]    jr_target,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [XLEN-1:0]    dec_pc
);

    localparam int unsigned QAW = $clog2(FQ_DEPTH);
    localparam int unsigned QW  = XLEN + INSTR_W;

    fetch_state_e        state_r;
    fetch_state_e        state_nxt_s;
    logic [XLEN-1:0]     fetch_pc_r;
    logic                run_r;
    logic                redirect_s;
    logic [XLEN-1:0]     seq_pc_s;
    logic [XLEN-1:0]     target_s;
    logic                req_valid_s;
    logic                push_s;
    logic                pop_s;
    logic                slot_free_s;
    logic [QW-1:0]       q_head_s;
    logic [QAW:0]        q_count_s;
    logic                q_full_s;
    logic                q_empty_s;

    assign redirect_s = jr | jump | (branch & zero_flag);
    assign seq_pc_s   = ex_pc + XLEN'(PC_INC);

    // Redirect target selection, jr has highest priority, then jump, then branch
    always_comb begin
        target_s = '0;
        if (jr) begin
            target_s = jr_target;
        end else if (jump) begin
            target_s = {seq_pc_s[XLEN-1:28], jump_index, 2'b00};
        end else begin
            target_s = seq_pc_s + {br_offset[XLEN-3:0], 2'b00};
        end
    end

    // A request reserves a queue slot: only issue while an entry is still free
    assign slot_free_s = (q_count_s < (QAW+1)'(FQ_DEPTH));

    // FSM next state plus request / push strobes
    always_comb begin
        state_nxt_s = state_r;
        req_valid_s = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_REQ: begin
                req_valid_s = run_r & slot_free_s & ~redirect_s;
                if (req_valid_s && imem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    // full can never be seen here; the guard only protects the queue
                    push_s      = ~redirect_s & ~q_full_s;
                    state_nxt_s = ST_REQ;
                end else if (redirect_s) begin
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holds requests off for the first cycle after reset so the request port reads 0 in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Fetch PC: redirect target, or advance once the current word is queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_s) begin
            fetch_pc_r <= target_s;
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(PC_INC);
        end
    end

    // The flush on redirect also covers a pop in the same cycle
    assign pop_s = dec_valid & dec_ready;

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_s),
        .push      (push_s),
        .push_data ({fetch_pc_r, imem_rsp_data}),
        .pop       (pop_s),
        .head_data (q_head_s),
        .count     (q_count_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;
    assign dec_valid      = ~q_empty_s & ~redirect_s;
    assign dec_instr      = q_head_s[INSTR_W-1:0];
    assign dec_pc         = q_head_s[QW-1:INSTR_W];

endmodule

// File: tb/tb_fetch_unit_prefetch.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit_prefetch
// Directed bench for fetch_unit_prefetch with a variable-latency memory model
// that returns the request address as the instruction word.
// ---------------------------------------------------------------------------
module tb_fetch_unit_prefetch;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned FQ_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic [XLEN-1:0]   ex_pc;
    logic              branch;
    logic              zero_flag;
    logic [XLEN-1:0]   br_offset;
    logic              jump;
    logic [25:0]       jump_index;
    logic              jr;
    logic [XLEN-1:0]   jr_target;
    logic              dec_valid;
    logic              dec_ready;
    logic [31:0]       dec_instr;
    logic [XLEN-1:0]   dec_pc;

    int vectors = 0;
    int miscompares = 0;

    // memory model state
    int          mem_lat = 1;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          acc_cnt;

    logic [31:0] got_pc [16];
    logic [31:0] got_instr [16];
    int          got_n;

    fetch_unit_prefetch #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ex_pc          (ex_pc),
        .branch         (branch),
        .zero_flag      (zero_flag),
        .br_offset      (br_offset),
        .jump           (jump),
        .jump_index     (jump_index),
        .jr             (jr),
        .jr_target      (jr_target),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    assign imem_rsp_data = mem_addr;

    // Instruction memory: accepts every request, answers mem_lat cycles later with data = address
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rsp_valid <= 1'b0;
            mem_busy       <= 1'b0;
            mem_cnt        <= 0;
            mem_addr       <= 32'h0;
            acc_cnt        <= 0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt  <= acc_cnt + 1;
                mem_addr <= imem_req_addr;
                if (mem_lat <= 1) begin
                    imem_rsp_valid <= 1'b1;
                end else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= mem_lat - 1;
                end
            end else if (mem_busy) begin
                if (mem_cnt <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    mem_busy       <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_ex();
        branch     = 1'b0;
        zero_flag  = 1'b0;
        jump       = 1'b0;
        jr         = 1'b0;
        ex_pc      = 32'h0;
        br_offset  = 32'h0;
        jump_index = 26'h0;
        jr_target  = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_ex();
        dec_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic collect(input int n);
        got_n = 0;
        for (int i = 0; i < 200 && got_n < n; i++) begin
            if (dec_valid && dec_ready) begin
                got_pc[got_n]    = dec_pc;
                got_instr[got_n] = dec_instr;
                got_n++;
            end
            if (got_n < n) step();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %0b want 0", imem_req_valid); end
        vectors++;
        if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dec_valid: got %0b want 0", dec_valid); end
        vectors++;
        if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_req_addr: got %h want 0", imem_req_addr); end
        vectors++;
        if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin miscompares++; $display("FAIL reset_dec_data: got pc %h instr %h want 0", dec_pc, dec_instr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_sequential();
        mem_lat = 1;
        do_reset();
        dec_ready = 1'b1;
        collect(6);
        vectors++;
        if (got_n !== 6) begin miscompares++; $display("FAIL seq_count: got %0d want 6", got_n); end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got_pc[k] !== 32'(4 * k) || got_instr[k] !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL seq_entry%0d: got pc %h instr %h want %h", k, got_pc[k], got_instr[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        do_reset();
        repeat (30) step();
        vectors++;
        if (acc_cnt !== FQ_DEPTH) begin miscompares++; $display("FAIL bp_accepted: got %0d want %0d", acc_cnt, FQ_DEPTH); end
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_stall: got %0b want 0", imem_req_valid); end
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head: got valid %0b pc %h want 1 0", dec_valid, dec_pc); end
        dec_ready = 1'b1;
        #1;
        collect(6);
        vectors++;
        if (got_n !== 6) begin miscompares++; $display("FAIL bp_drain_count: got %0d want 6", got_n); end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got_pc[k] !== 32'(4 * k) || got_instr[k] !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL bp_drain%0d: got pc %h instr %h want %h", k, got_pc[k], got_instr[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_branch_flush();
        bit ok;
        mem_lat = 3;
        do_reset();
        dec_ready = 1'b1;
        wait_req(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL br_first_req: got timeout want request"); end
        step();
        branch    = 1'b1;
        zero_flag = 1'b1;
        ex_pc     = 32'h0000_0010;
        br_offset = 32'h0000_0003;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin miscompares++; $display("FAIL br_redirect_cycle: got req %0b dec %0b want 0 0", imem_req_valid, dec_valid); end
        step();
        clear_ex();
        #1;
        vectors++;
        if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL br_queue_empty: got %0b want 0", dec_valid); end
        wait_req(ok);
        vectors++;
        if (!ok || imem_req_addr !== 32'h0000_0020) begin miscompares++; $display("FAIL br_target_addr: got ok %0b addr %h want 1 00000020", ok, imem_req_addr); end
        vectors++;
        if (acc_cnt !== 1) begin miscompares++; $display("FAIL br_no_extra_req: got %0d want 1", acc_cnt); end
        collect(1);
        vectors++;
        if (got_n !== 1 || got_pc[0] !== 32'h20 || got_instr[0] !== 32'h20) begin miscompares++; $display("FAIL br_first_dec: got n %0d pc %h instr %h want 00000020", got_n, got_pc[0], got_instr[0]); end
    endtask

    task automatic test_jump();
        bit ok;
        mem_lat = 1;
        do_reset();
        dec_ready = 1'b1;
        repeat (5) step();
        jump       = 1'b1;
        ex_pc      = 32'hF000_0000;
        jump_index = 26'h40;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin miscompares++; $display("FAIL jump_redirect_cycle: got req %0b dec %0b want 0 0", imem_req_valid, dec_valid); end
        step();
        clear_ex();
        #1;
        wait_req(ok);
        vectors++;
        if (!ok || imem_req_addr !== 32'hF000_0100) begin miscompares++; $display("FAIL jump_addr: got ok %0b addr %h want F0000100", ok, imem_req_addr); end
        collect(1);
        vectors++;
        if (got_n !== 1 || got_pc[0] !== 32'hF000_0100) begin miscompares++; $display("FAIL jump_dec: got n %0d pc %h want F0000100", got_n, got_pc[0]); end
        jr         = 1'b1;
        jr_target  = 32'h0000_1230;
        jump       = 1'b1;
        jump_index = 26'h3FF;
        ex_pc      = 32'h4000_0000;
        #1;
        step();
        clear_ex();
        #1;
        wait_req(ok);
        vectors++;
        if (!ok || imem_req_addr !== 32'h0000_1230) begin miscompares++; $display("FAIL jr_priority_addr: got ok %0b addr %h want 00001230", ok, imem_req_addr); end
        collect(1);
        vectors++;
        if (got_n !== 1 || got_pc[0] !== 32'h0000_1230) begin miscompares++; $display("FAIL jr_dec: got n %0d pc %h want 00001230", got_n, got_pc[0]); end
    endtask

    task automatic test_branch_not_taken();
        bit ok;
        mem_lat = 1;
        do_reset();
        dec_ready = 1'b1;
        branch    = 1'b1;
        zero_flag = 1'b0;
        ex_pc     = 32'h0000_0100;
        br_offset = 32'h0000_0005;
        #1;
        collect(4);
        vectors++;
        if (got_n !== 4) begin miscompares++; $display("FAIL nt_count: got %0d want 4", got_n); end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got_pc[k] !== 32'(4 * k)) begin miscompares++; $display("FAIL nt_entry%0d: got %h want %h", k, got_pc[k], 32'(4 * k)); end
        end
        zero_flag = 1'b1;
        ex_pc     = 32'h0000_0000;
        br_offset = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_redirect_dec: got %0b want 0", dec_valid); end
        step();
        clear_ex();
        #1;
        wait_req(ok);
        vectors++;
        if (!ok || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got ok %0b addr %h want 00000000", ok, imem_req_addr); end
        collect(1);
        vectors++;
        if (got_n !== 1 || got_pc[0] !== 32'h0) begin miscompares++; $display("FAIL wrap_dec: got n %0d pc %h want 00000000", got_n, got_pc[0]); end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        bit seen;
        mem_lat = 3;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dec_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rst_fill: got timeout want queued entry"); end
        wait_req(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rst_second_req: got timeout want request"); end
        step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_outputs: got dec %0b req %0b want 0 0", dec_valid, imem_req_valid); end
        vectors++;
        if (imem_req_addr !== 32'h0 || dec_pc !== 32'h0) begin miscompares++; $display("FAIL rst_mid_pc: got addr %h dec_pc %h want 0", imem_req_addr, dec_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        wait_req(ok);
        vectors++;
        if (!ok || imem_req_addr !== 32'h0 || acc_cnt !== 0) begin miscompares++; $display("FAIL rst_restart: got ok %0b addr %h acc %0d want 1 0 0", ok, imem_req_addr, acc_cnt); end
        dec_ready = 1'b1;
        #1;
        collect(1);
        vectors++;
        if (got_n !== 1 || got_pc[0] !== 32'h0 || got_instr[0] !== 32'h0) begin miscompares++; $display("FAIL rst_first_dec: got n %0d pc %h instr %h want 0", got_n, got_pc[0], got_instr[0]); end
    endtask

    initial begin
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        clear_ex();
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_flush();
        test_jump();
        test_branch_not_taken();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
